// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register plus the EX-stage operand selector that feeds the
// ALU of the 5-stage MIPS core.
//
// Each rising edge either captures the decoded ID-stage operands and control,
// or loads a bubble when the hazard unit stalls or the branch logic flushes.
// M->E and W->E forwarding is resolved combinationally from the registered
// rs/rt indices. The block then selects ALUIn1/ALUIn2 and passes the
// store-data operand and write-back control on to EX/MEM.
//
// Ports
//   clk, reset          : rising-edge clock; asynchronous active-low reset
//   stall, flush        : either one high at an edge loads a bubble into EX
//   *_D                 : decoded operands/control from the ID stage
//   ALUOut_M, WriteReg_M, RegWrite_M, MemtoReg_M : M-stage forwarding source
//   WD_W, WriteReg_W, RegWrite_W                 : W-stage forwarding source
//   ALUIn1, ALUIn2, ALUOp                        : ALU operands and operation
//   WriteData_E         : forwarded rt value used by stores
//   WriteReg_E, RegWrite_E, MemWrite_E, MemtoReg_E, PC8_E : registered controls
//   Valid_E             : EX holds a real instruction
//
// Valid_E is a pure qualifier with no ready/back-pressure. When it is 1, every
// E output describes one real instruction for exactly this cycle. When it is
// 0, EX holds a bubble: all controls are 0 and ALUOp is NOP_OP.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int          DW     = 32,
  parameter int          RW     = 5,
  parameter logic [2:0]  NOP_OP = 3'b000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] RD1_D,
  input  logic [DW-1:0] RD2_D,
  input  logic [DW-1:0] Imm_D,
  input  logic [4:0]    Shamt_D,
  input  logic [RW-1:0] rs_D,
  input  logic [RW-1:0] rt_D,
  input  logic [RW-1:0] WriteReg_D,
  input  logic [2:0]    ALUOp_D,
  input  logic          ALUSrc_D,
  input  logic          RegWrite_D,
  input  logic          MemWrite_D,
  input  logic          MemtoReg_D,
  input  logic [DW-1:0] PC8_D,
  input  logic [DW-1:0] ALUOut_M,
  input  logic [RW-1:0] WriteReg_M,
  input  logic          RegWrite_M,
  input  logic          MemtoReg_M,
  input  logic [DW-1:0] WD_W,
  input  logic [RW-1:0] WriteReg_W,
  input  logic          RegWrite_W,
  output logic [DW-1:0] ALUIn1,
  output logic [DW-1:0] ALUIn2,
  output logic [2:0]    ALUOp,
  output logic [DW-1:0] WriteData_E,
  output logic [RW-1:0] WriteReg_E,
  output logic          RegWrite_E,
  output logic          MemWrite_E,
  output logic          MemtoReg_E,
  output logic [DW-1:0] PC8_E,
  output logic          Valid_E
);

  localparam logic [2:0] OP_SLL = 3'b011;

  // ---------------------------------------------------------------------------
  // E-stage registers
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [DW-1:0] r_imm;
  logic [4:0]    r_shamt;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_write_reg;
  logic [2:0]    r_alu_op;
  logic          r_alu_src;
  logic          r_reg_write;
  logic          r_mem_write;
  logic          r_mem_to_reg;
  logic [DW-1:0] r_pc8;
  logic          r_valid;

  logic          w_bubble;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;
  logic [DW-1:0] w_shamt_ext;

  // stall and flush together still produce a single bubble
  assign w_bubble = stall | flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_write_reg  <= '0;
      r_alu_op     <= NOP_OP;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc8        <= '0;
      r_valid      <= 1'b0;
    end else if (w_bubble) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_write_reg  <= '0;
      r_alu_op     <= NOP_OP;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_pc8        <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_rd1        <= RD1_D;
      r_rd2        <= RD2_D;
      r_imm        <= Imm_D;
      r_shamt      <= Shamt_D;
      r_rs         <= rs_D;
      r_rt         <= rt_D;
      r_write_reg  <= WriteReg_D;
      r_alu_op     <= ALUOp_D;
      r_alu_src    <= ALUSrc_D;
      r_reg_write  <= RegWrite_D;
      r_mem_write  <= MemWrite_D;
      r_mem_to_reg <= MemtoReg_D;
      r_pc8        <= PC8_D;
      r_valid      <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding: M beats W. $0 is never forwarded. A load sitting in M is not
  // forwarded because its data does not exist yet; the hazard unit stalls
  // that case, so the W path (or the register value) is used instead.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fwd_rs = r_rd1;
    if ((r_rs != '0) && RegWrite_M && (WriteReg_M == r_rs) && !MemtoReg_M)
      w_fwd_rs = ALUOut_M;
    else if ((r_rs != '0) && RegWrite_W && (WriteReg_W == r_rs))
      w_fwd_rs = WD_W;
  end

  always_comb begin
    w_fwd_rt = r_rd2;
    if ((r_rt != '0) && RegWrite_M && (WriteReg_M == r_rt) && !MemtoReg_M)
      w_fwd_rt = ALUOut_M;
    else if ((r_rt != '0) && RegWrite_W && (WriteReg_W == r_rt))
      w_fwd_rt = WD_W;
  end

  assign w_shamt_ext = {{(DW-5){1'b0}}, r_shamt};

  // ---------------------------------------------------------------------------
  // Operand selection: sll shifts the rt value by shamt. Every other op uses
  // rs, with the immediate replacing rt when ALUSrc is set.
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUIn1 = w_fwd_rs;
    ALUIn2 = r_alu_src ? r_imm : w_fwd_rt;
    if (r_alu_op == OP_SLL) begin
      ALUIn1 = w_shamt_ext;
      ALUIn2 = w_fwd_rt;
    end
  end

  assign ALUOp       = r_alu_op;
  assign WriteData_E = w_fwd_rt;
  assign WriteReg_E  = r_write_reg;
  assign RegWrite_E  = r_reg_write;
  assign MemWrite_E  = r_mem_write;
  assign MemtoReg_E  = r_mem_to_reg;
  assign PC8_E       = r_pc8;
  assign Valid_E     = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Each cycle the driver applies D-stage and M/W-stage inputs. It then pushes
// the E-stage outputs expected for the instruction currently in EX onto
// exp_q. A negedge monitor pops one entry per cycle and compares it against
// the DUT. The reference model tracks which instruction (or bubble) occupies
// EX, and applies the forwarding and operand rules directly.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int         DW     = 32;
  localparam int         RW     = 5;
  localparam logic [2:0] NOP_OP = 3'b000;

  typedef struct packed {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wr;
    logic [2:0]    op;
    logic          alu_src;
    logic          reg_write;
    logic          mem_write;
    logic          mem_to_reg;
    logic [DW-1:0] pc8;
  } d_t;

  typedef struct packed {
    logic [DW-1:0] alu_out_m;
    logic [RW-1:0] wr_m;
    logic          rw_m;
    logic          m2r_m;
    logic [DW-1:0] wd_w;
    logic [RW-1:0] wr_w;
    logic          rw_w;
  } mw_t;

  typedef struct packed {
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [2:0]    op;
    logic [DW-1:0] wd;
    logic [RW-1:0] wr;
    logic          rw;
    logic          mw;
    logic          m2r;
    logic [DW-1:0] pc8;
    logic          valid;
  } e_t;

  localparam int EXP_W = $bits(e_t);

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          reset;
  logic          stall, flush;
  logic [DW-1:0] rd1_d, rd2_d, imm_d, pc8_d;
  logic [4:0]    shamt_d;
  logic [RW-1:0] rs_d, rt_d, write_reg_d;
  logic [2:0]    alu_op_d;
  logic          alu_src_d, reg_write_d, mem_write_d, mem_to_reg_d;
  logic [DW-1:0] alu_out_m;
  logic [RW-1:0] write_reg_m;
  logic          reg_write_m, mem_to_reg_m;
  logic [DW-1:0] wd_w;
  logic [RW-1:0] write_reg_w;
  logic          reg_write_w;
  logic [DW-1:0] alu_in1, alu_in2, write_data_e, pc8_e;
  logic [2:0]    alu_op_e;
  logic [RW-1:0] write_reg_e;
  logic          reg_write_e, mem_write_e, mem_to_reg_e, valid_e;

  id_ex_stage #(.DW(DW), .RW(RW), .NOP_OP(NOP_OP)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .RD1_D       (rd1_d),
    .RD2_D       (rd2_d),
    .Imm_D       (imm_d),
    .Shamt_D     (shamt_d),
    .rs_D        (rs_d),
    .rt_D        (rt_d),
    .WriteReg_D  (write_reg_d),
    .ALUOp_D     (alu_op_d),
    .ALUSrc_D    (alu_src_d),
    .RegWrite_D  (reg_write_d),
    .MemWrite_D  (mem_write_d),
    .MemtoReg_D  (mem_to_reg_d),
    .PC8_D       (pc8_d),
    .ALUOut_M    (alu_out_m),
    .WriteReg_M  (write_reg_m),
    .RegWrite_M  (reg_write_m),
    .MemtoReg_M  (mem_to_reg_m),
    .WD_W        (wd_w),
    .WriteReg_W  (write_reg_w),
    .RegWrite_W  (reg_write_w),
    .ALUIn1      (alu_in1),
    .ALUIn2      (alu_in2),
    .ALUOp       (alu_op_e),
    .WriteData_E (write_data_e),
    .WriteReg_E  (write_reg_e),
    .RegWrite_E  (reg_write_e),
    .MemWrite_E  (mem_write_e),
    .MemtoReg_E  (mem_to_reg_e),
    .PC8_E       (pc8_e),
    .Valid_E     (valid_e)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] exp_q[$];
  d_t               ex_m;        // instruction the model believes is in EX
  logic             ex_valid_m;
  d_t               bubble;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx, input logic [DW-1:0] regval,
                                        input mw_t mw);
    if (idx != 0 && mw.rw_m && mw.wr_m == idx && !mw.m2r_m) return mw.alu_out_m;
    if (idx != 0 && mw.rw_w && mw.wr_w == idx) return mw.wd_w;
    return regval;
  endfunction

  function automatic e_t model_out(input d_t ex, input logic v, input mw_t mw);
    e_t e;
    logic [DW-1:0] rs_v;
    logic [DW-1:0] rt_v;
    rs_v = fwd(ex.rs, ex.rd1, mw);
    rt_v = fwd(ex.rt, ex.rd2, mw);
    if (ex.op == 3'b011) begin
      e.in1 = DW'(ex.shamt);
      e.in2 = rt_v;
    end else begin
      e.in1 = rs_v;
      e.in2 = ex.alu_src ? ex.imm : rt_v;
    end
    e.op    = ex.op;
    e.wd    = rt_v;
    e.wr    = ex.wr;
    e.rw    = ex.reg_write;
    e.mw    = ex.mem_write;
    e.m2r   = ex.mem_to_reg;
    e.pc8   = ex.pc8;
    e.valid = v;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic d_t rand_d();
    d_t d;
    d.rd1        = $urandom;
    d.rd2        = $urandom;
    d.imm        = $urandom;
    d.shamt      = 5'($urandom_range(0, 31));
    d.rs         = RW'($urandom_range(0, 7));
    d.rt         = RW'($urandom_range(0, 7));
    d.wr         = RW'($urandom_range(0, 31));
    d.op         = 3'($urandom_range(0, 3));
    d.alu_src    = 1'($urandom_range(0, 1));
    d.reg_write  = 1'($urandom_range(0, 1));
    d.mem_write  = 1'($urandom_range(0, 1));
    d.mem_to_reg = 1'($urandom_range(0, 1));
    d.pc8        = $urandom;
    return d;
  endfunction

  // Destinations are biased toward the EX instruction's rs/rt to hit forwarding.
  function automatic logic [RW-1:0] pick_dst();
    case ($urandom_range(0, 3))
      0:       return ex_m.rs;
      1:       return ex_m.rt;
      default: return RW'($urandom_range(0, 7));
    endcase
  endfunction

  function automatic mw_t rand_mw();
    mw_t mw;
    mw.alu_out_m = $urandom;
    mw.wr_m      = pick_dst();
    mw.rw_m      = 1'($urandom_range(0, 1));
    mw.m2r_m     = ($urandom_range(0, 3) == 0);
    mw.wd_w      = $urandom;
    mw.wr_w      = pick_dst();
    mw.rw_w      = 1'($urandom_range(0, 1));
    return mw;
  endfunction

  task automatic apply(input d_t d, input mw_t mw, input logic st, input logic fl);
    rd1_d        = d.rd1;
    rd2_d        = d.rd2;
    imm_d        = d.imm;
    shamt_d      = d.shamt;
    rs_d         = d.rs;
    rt_d         = d.rt;
    write_reg_d  = d.wr;
    alu_op_d     = d.op;
    alu_src_d    = d.alu_src;
    reg_write_d  = d.reg_write;
    mem_write_d  = d.mem_write;
    mem_to_reg_d = d.mem_to_reg;
    pc8_d        = d.pc8;
    alu_out_m    = mw.alu_out_m;
    write_reg_m  = mw.wr_m;
    reg_write_m  = mw.rw_m;
    mem_to_reg_m = mw.m2r_m;
    wd_w         = mw.wd_w;
    write_reg_w  = mw.wr_w;
    reg_write_w  = mw.rw_w;
    stall        = st;
    flush        = fl;
  endtask

  // Called just after a rising edge: drive one cycle, record the expected
  // E outputs for this cycle, advance the model across the next edge.
  task automatic issue(input d_t d, input mw_t mw, input logic st, input logic fl);
    apply(d, mw, st, fl);
    exp_q.push_back(EXP_W'(model_out(ex_m, ex_valid_m, mw)));
    if (st || fl) begin
      ex_m       = bubble;
      ex_valid_m = 1'b0;
    end else begin
      ex_m       = d;
      ex_valid_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu_in1"},   alu_in1, '0);
    check({tag, "_alu_in2"},   alu_in2, '0);
    check({tag, "_alu_op"},    DW'(alu_op_e), DW'(NOP_OP));
    check({tag, "_wdata"},     write_data_e, '0);
    check({tag, "_wreg"},      DW'(write_reg_e), '0);
    check({tag, "_regwrite"},  DW'(reg_write_e), '0);
    check({tag, "_memwrite"},  DW'(mem_write_e), '0);
    check({tag, "_memtoreg"},  DW'(mem_to_reg_e), '0);
    check({tag, "_pc8"},       pc8_e, '0);
    check({tag, "_valid"},     DW'(valid_e), '0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    e_t e;
    if (exp_q.size() > 0) begin
      e = e_t'(exp_q.pop_front());
      check("alu_in1",  alu_in1, e.in1);
      check("alu_in2",  alu_in2, e.in2);
      check("alu_op",   DW'(alu_op_e), DW'(e.op));
      check("wdata_e",  write_data_e, e.wd);
      check("wreg_e",   DW'(write_reg_e), DW'(e.wr));
      check("regwr_e",  DW'(reg_write_e), DW'(e.rw));
      check("memwr_e",  DW'(mem_write_e), DW'(e.mw));
      check("mem2reg_e", DW'(mem_to_reg_e), DW'(e.m2r));
      check("pc8_e",    pc8_e, e.pc8);
      check("valid_e",  DW'(valid_e), DW'(e.valid));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    d_t  d;
    mw_t none;
    mw_t mw;

    bubble     = '0;
    bubble.op  = NOP_OP;
    ex_m       = bubble;
    ex_valid_m = 1'b0;
    none       = '0;

    reset = 1'b0;
    apply(bubble, none, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_init");
    reset = 1'b1;

    for (int i = 0; i < 5; i++) issue(rand_d(), rand_mw(), 1'b0, 1'b0);

    // addu pass-through, no forwarding
    d = '0; d.rs = 3; d.rd1 = 32'd5; d.rt = 4; d.rd2 = 32'd7; d.wr = 2; d.reg_write = 1'b1;
    issue(d, none, 1'b0, 1'b0);
    issue(rand_d(), none, 1'b0, 1'b0);

    // M over W priority, then W alone, then a load in M (falls back to W)
    d = '0; d.rs = 8; d.rd1 = 32'h99; d.rt = 1; d.rd2 = 32'h3; d.reg_write = 1'b1;
    issue(d, none, 1'b0, 1'b0);
    mw = '0; mw.alu_out_m = 32'h11; mw.wr_m = 8; mw.rw_m = 1'b1;
    mw.wd_w = 32'h22; mw.wr_w = 8; mw.rw_w = 1'b1;
    issue(d, mw, 1'b0, 1'b0);
    mw.rw_m = 1'b0;
    issue(d, mw, 1'b0, 1'b0);
    mw.rw_m = 1'b1; mw.m2r_m = 1'b1;
    issue(rand_d(), mw, 1'b0, 1'b0);

    // $0 never forwarded
    d = '0; d.rs = 0; d.rt = 0; d.reg_write = 1'b1;
    issue(d, none, 1'b0, 1'b0);
    mw = '0; mw.alu_out_m = 32'hFFFF; mw.wr_m = 0; mw.rw_m = 1'b1;
    mw.wd_w = 32'h1234; mw.wr_w = 0; mw.rw_w = 1'b1;
    issue(rand_d(), mw, 1'b0, 1'b0);

    // sll with rt from W, then ori with rt from M
    d = '0; d.op = 3'b011; d.shamt = 5'd4; d.rt = 6; d.rd2 = 32'h77; d.rs = 1; d.rd1 = 32'h55;
    issue(d, none, 1'b0, 1'b0);
    d = '0; d.op = 3'b010; d.imm = 32'hFF; d.alu_src = 1'b1; d.rt = 9; d.rd2 = 32'h5;
    mw = '0; mw.wd_w = 32'h3; mw.wr_w = 6; mw.rw_w = 1'b1;
    issue(d, mw, 1'b0, 1'b0);
    mw = '0; mw.alu_out_m = 32'hAB; mw.wr_m = 9; mw.rw_m = 1'b1;
    issue(rand_d(), mw, 1'b0, 1'b0);

    // stall holding a sw, then release; stall+flush; flush alone
    d = '0; d.op = 3'b000; d.alu_src = 1'b1; d.imm = 32'h4; d.rs = 2; d.rd1 = 32'h100;
    d.rt = 3; d.rd2 = 32'hCAFE; d.mem_write = 1'b1; d.pc8 = 32'h408;
    issue(d, none, 1'b1, 1'b0);
    issue(d, none, 1'b0, 1'b0);
    issue(rand_d(), none, 1'b1, 1'b1);
    issue(rand_d(), none, 1'b0, 1'b0);
    issue(rand_d(), rand_mw(), 1'b0, 1'b1);
    issue(rand_d(), rand_mw(), 1'b0, 1'b0);

    // asynchronous reset mid-cycle with busy inputs; first edge after release loads D
    d = rand_d(); d.rs = 5; d.rt = 6; d.op = 3'b001; d.reg_write = 1'b1;
    d.pc8 = d.pc8 | 32'h1; d.rd1 = d.rd1 | 32'h1; d.rd2 = d.rd2 | 32'h1;
    mw = '0; mw.alu_out_m = 32'hDEAD; mw.wr_m = 7; mw.rw_m = 1'b1;
    mw.wd_w = 32'hBEEF; mw.wr_w = 4; mw.rw_w = 1'b1;
    apply(d, mw, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1 check_zero("rst_mid");
    #1 reset = 1'b1;
    ex_m       = d;
    ex_valid_m = 1'b1;
    @(posedge clk);
    #1;
    issue(rand_d(), rand_mw(), 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(rand_d(), rand_mw(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    check("queue_drain", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and EX-stage operand selector for the 5-stage MIPS core, directly upstream of the ALU.
- Captures decoded operands and control from ID each cycle.
- Inserts bubbles on hazard-unit stall or flush.
- Resolves M→E and W→E data forwarding.
- Drives ALUIn1, ALUIn2 and ALUOp into the ALU; passes the store-data operand and write-back control to EX/MEM.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.
- NOP_OP, 3'b000, ALUOp value held while a bubble occupies EX.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous reset, active-low; clears the stage to a bubble.
- stall  input  1  from hazard unit: load-use stall; EX takes a bubble this edge.
- flush  input  1  from branch logic: squash the instruction entering EX.
- RD1_D  input  DW  GRF rs read data (already D-stage forwarded).
- RD2_D  input  DW  GRF rt read data.
- Imm_D  input  DW  extended immediate.
- Shamt_D  input  5  instr[10:6].
- rs_D  input  RW  rs index.
- rt_D  input  RW  rt index.
- WriteReg_D  input  RW  destination register index.
- ALUOp_D  input  3  ALU operation: 000 add, 001 sub, 010 or, 011 sll.
- ALUSrc_D  input  1  1 selects Imm_D as ALUIn2.
- RegWrite_D  input  1  write-back enable.
- MemWrite_D  input  1  store enable.
- MemtoReg_D  input  1  load-result select.
- PC8_D  input  DW  PC+8 for jal.
- ALUOut_M  input  DW  M-stage result.
- WriteReg_M  input  RW  M-stage destination.
- RegWrite_M  input  1  M-stage write enable.
- MemtoReg_M  input  1  M-stage instruction is a load.
- WD_W  input  DW  W-stage write-back data.
- WriteReg_W  input  RW  W-stage destination.
- RegWrite_W  input  1  W-stage write enable.
- ALUIn1  output  DW  ALU operand 1.
- ALUIn2  output  DW  ALU operand 2.
- ALUOp  output  3  registered ALU operation.
- WriteData_E  output  DW  forwarded rt value, for stores.
- WriteReg_E  output  RW  registered destination.
- RegWrite_E  output  1  registered write enable.
- MemWrite_E  output  1  registered store enable.
- MemtoReg_E  output  1  registered load-result select.
- PC8_E  output  DW  registered PC+8.
- Valid_E  output  1  1 when EX holds a real instruction.

Behaviour:
- Register update
  - All E registers load on the rising clk edge.
  - Reset is asynchronous: reset=0 immediately forces every register to 0, ALUOp to NOP_OP and Valid_E to 0, independent of clk. Deassertion takes effect at the next edge.
- Bubble
  - If stall or flush is 1 at an edge, load a bubble: RegWrite_E=0, MemWrite_E=0, MemtoReg_E=0, WriteReg_E=0, ALUOp=NOP_OP, Valid_E=0, data registers 0.
  - stall and flush both high is identical to a single bubble.
  - Otherwise load the D values and set Valid_E=1.
- Forwarding (combinational, from registered rs_E/rt_E)
  - Source of rs_E: ALUOut_M if RegWrite_M and WriteReg_M==rs_E and rs_E!=0 and !MemtoReg_M.
  - Else WD_W if RegWrite_W and WriteReg_W==rs_E and rs_E!=0.
  - Else RD1_E.
  - rt_E uses the same rules with RD2_E.
  - M has priority over W.
  - $0 is never forwarded; it always reads the registered value.
  - A load in M is never forwarded; the hazard unit guarantees a stall.
- Operand selection
  - ALUOp==011 (sll): ALUIn1 = zero-extended Shamt_E; ALUIn2 = forwarded rt.
  - Otherwise: ALUIn1 = forwarded rs; ALUIn2 = ALUSrc_E ? Imm_E : forwarded rt.
  - WriteData_E = forwarded rt always, regardless of ALUSrc.
- Latency: 1 cycle from D inputs to E outputs. Forwarding muxes add 0 cycles.
- Width rules: no arithmetic in this block; Shamt zero-extended to DW.

Test Plan:
- Reset: drive reset=0 mid-cycle with all inputs nonzero → outputs 0 and Valid_E=0 before the next edge; after release, first edge loads D.
- Pass-through: addu rs=3 (RD1=5), rt=4 (RD2=7), ALUSrc=0, no forwards → next cycle ALUIn1=5, ALUIn2=7, ALUOp=000, Valid_E=1.
- Forward priority: rs_E=8, WriteReg_M=8 with ALUOut_M=0x11, WriteReg_W=8 with WD_W=0x22, both RegWrite=1 → ALUIn1=0x11; drop RegWrite_M → ALUIn1=0x22.
- Zero register: rs_E=0, WriteReg_M=0, RegWrite_M=1, ALUOut_M=0xFFFF → ALUIn1=RD1_E (0).
- sll/ori select: sll Shamt=4, rt forwarded from W=0x3 → ALUIn1=4, ALUIn2=3. ori Imm=0x00FF, ALUSrc=1, rt forwarded=0xAB → ALUIn2=0xFF, WriteData_E=0xAB.
- Stall/flush: stall=1 for one edge while D holds sw → RegWrite_E=MemWrite_E=0, Valid_E=0; next edge with stall=0 loads sw (MemWrite_E=1). stall+flush together → single bubble.
